// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Collects a big-endian byte stream over a valid/ready handshake, packs each
// group of DATA_WIDTH/8 bytes into one instruction word and writes the words
// to consecutive addresses (wrapping modulo 2^ADDR_WIDTH). cpu_hold freezes
// the fetch PC while a load is in progress.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a running XOR of all
// words written during the current load on output 'checksum'.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD + 1);
    localparam int WCNT_W         = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      byte_cnt;
    logic [WCNT_W-1:0]     word_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] asm_word;
    logic [DATA_WIDTH-1:0] asm_next;

    // Shift the incoming byte in at the bottom so the first byte ends up in the MSBs
    always_comb begin
        asm_next = (asm_word << 8) | DATA_WIDTH'(byte_data);
    end

    assign cpu_hold = busy;

    // Loader FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            addr       <= '0;
            asm_word   <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum <= '0;
`endif
                        if (load_count != '0) begin
                            addr       <= load_base;
                            word_cnt   <= load_count;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_COLLECT;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

                S_COLLECT: begin
                    if (byte_valid) begin
                        asm_word <= asm_next;
                        if (byte_cnt == CNT_W'(BYTES_PER_WORD - 1)) begin
                            byte_cnt   <= '0;
                            byte_ready <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_waddr <= addr;
                            imem_wdata <= asm_next;
                            state      <= S_WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end

                S_WRITE: begin
                    imem_we  <= 1'b0;
                    addr     <= addr + ADDR_WIDTH'(1);
                    word_cnt <= word_cnt - WCNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum <= checksum ^ imem_wdata;
`endif
                    if (word_cnt == WCNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        byte_ready <= 1'b1;
                        state      <= S_COLLECT;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    byte_ready <= 1'b0;
                    imem_we    <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed test of imem_loader with hand-computed expected
// words, addresses and handshake timing. Define IMEM_LOADER_CHECKSUM_EN to
// also exercise the checksum output.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic [7:0]  load_base;
    logic [8:0]  load_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        cpu_hold;
    logic        done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
    logic [31:0] cks_at_done;
`endif

    imem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_base  (load_base),
        .load_count (load_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  stim [8];
    logic [7:0]  wa [$];
    logic [31:0] wd [$];
    int          done_at;
    int          done_seen;
    int          hold_low;
    int          partial;
    int          hold_at_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse load_start for one cycle; returns at the negedge of the cycle after the accepting edge
    task automatic start_load(input logic [7:0] base, input logic [8:0] cnt);
        load_start = 1'b1;
        load_base  = base;
        load_count = cnt;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Stream nb bytes from stim[], logging writes, until done or the cycle budget expires
    task automatic run_load(input int nb, input bit toggle, input int max_cyc);
        int idx;
        bit phase;
        wa.delete();
        wd.delete();
        idx       = 0;
        phase     = 1'b1;
        done_at   = -1;
        done_seen = 0;
        hold_low  = 0;
        partial   = 0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            if (imem_we) begin
                wa.push_back(imem_waddr);
                wd.push_back(imem_wdata);
                if (idx == 0 || (idx % 4) != 0) partial++;
            end
            if (done) begin
                done_at      = cyc;
                done_seen    = 1;
                hold_at_done = int'(cpu_hold);
`ifdef IMEM_LOADER_CHECKSUM_EN
                cks_at_done  = checksum;
`endif
                break;
            end
            if (!cpu_hold || !busy) hold_low++;
            byte_valid = (idx < nb) && (!toggle || phase);
            byte_data  = (idx < nb) ? stim[idx] : 8'h00;
            if (byte_valid && byte_ready) idx++;
            phase = ~phase;
            @(negedge clk);
        end
        check("done_seen", done_seen, 1);
        byte_valid = 1'b0;
        @(negedge clk);
        check("done_one_pulse", done, 0);
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        load_base  = '0;
        load_count = '0;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;

        // Reset with byte_valid asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", byte_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", done, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("rst_cks", checksum, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", byte_ready, 0);
        byte_valid = 1'b0;

        // Basic load: 2 words at 0x10, valid held high
        stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        start_load(8'h10, 9'd2);
        check("lat_ready", byte_ready, 1);
        check("lat_hold", cpu_hold, 1);
        run_load(8, 1'b0, 40);
        check("basic_nw", wa.size(), 2);
        if (wa.size() >= 2) begin
            check("basic_a0", wa[0], 8'h10);
            check("basic_d0", wd[0], 32'h12345678);
            check("basic_a1", wa[1], 8'h11);
            check("basic_d1", wd[1], 32'h9ABCDEF0);
        end
        check("basic_done_at", done_at, 10);
        check("basic_hold", hold_low, 0);
        check("basic_hold_done", hold_at_done, 0);
        check("basic_partial", partial, 0);

        // Address wrap with byte_valid toggling
        stim = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
        start_load(8'hFF, 9'd2);
        run_load(8, 1'b1, 60);
        check("wrap_nw", wa.size(), 2);
        if (wa.size() >= 2) begin
            check("wrap_a0", wa[0], 8'hFF);
            check("wrap_d0", wd[0], 32'hA1B2C3D4);
            check("wrap_a1", wa[1], 8'h00);
            check("wrap_d1", wd[1], 32'hE5F60718);
        end
        check("wrap_partial", partial, 0);
        check("wrap_hold", hold_low, 0);

        // Zero count: done the cycle after load_start, no write
        start_load(8'h33, 9'd0);
        check("zero_done", done, 1);
        check("zero_we", imem_we, 0);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_done_clr", done, 0);
        check("zero_ready", byte_ready, 0);

        // Second load_start during COLLECT is ignored
        stim = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h00, 8'h00, 8'h00, 8'h00};
        start_load(8'h40, 9'd1);
        start_load(8'h80, 9'd3);
        run_load(4, 1'b0, 30);
        check("ign_nw", wa.size(), 1);
        if (wa.size() >= 1) begin
            check("ign_a0", wa[0], 8'h40);
            check("ign_d0", wd[0], 32'hCAFEBABE);
        end

        // Abort after 2 bytes, then a clean load from a new base
        start_load(8'h20, 9'd1);
        byte_valid = 1'b1;
        byte_data  = 8'h11;
        @(negedge clk);
        byte_data  = 8'h22;
        @(negedge clk);
        byte_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_we", imem_we, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", byte_ready, 0);
        @(negedge clk);
        check("abort_we2", imem_we, 0);
        check("abort_done2", done, 0);
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        start_load(8'h30, 9'd1);
        run_load(4, 1'b0, 30);
        check("post_abort_nw", wa.size(), 1);
        if (wa.size() >= 1) begin
            check("post_abort_a0", wa[0], 8'h30);
            check("post_abort_d0", wd[0], 32'h01020304);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum of 0xFFFF0000 ^ 0x0F0F0F0F
        stim = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
        start_load(8'h50, 9'd2);
        check("cks_clear", checksum, 0);
        run_load(8, 1'b0, 40);
        check("cks_done", cks_at_done, 32'hF0F00F0F);
        check("cks_stable", checksum, 32'hF0F00F0F);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
